weight_buffer_loader: RTL



---
 rtl/weight_buffer_loader.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/weight_buffer_loader.sv
`default_nettype none
// ============================================================================
//  Module      : weight_buffer_loader
//  Description : Write-side distributor for the per-column weight FIFOs of
//                the systolic array. A single row-major weight stream
//                (valid/ready) is spread across SYS_COLS column FIFOs:
//                beat k goes to column k mod SYS_COLS, row k div SYS_COLS.
//                Reports tile completion (done) and protocol errors (err).
//
//  Ports       : clk, rst            clock, synchronous active-high reset
//                start, tile_rows    begin a tile load / rows per column
//                s_valid, s_ready,   weight stream handshake, data and
//                s_data, s_last      end-of-tile marker
//                fifo_full           per-column FIFO full flags
//                wr_en, din          per-column FIFO write enable / data
//                                    (lane c is din[c*W_BITWIDTH +: W_BITWIDTH])
//                busy, done, err     status to the controller
//
//  Revision    : 1.0 - initial release
// ============================================================================
module weight_buffer_loader #(
    parameter int SYS_COLS   = 4,
    parameter int W_BITWIDTH = 8,
    parameter int MAX_ROWS   = 64,
    parameter int ROW_W      = $clog2(MAX_ROWS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ROW_W-1:0]               tile_rows,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [W_BITWIDTH-1:0]          s_data,
    input  logic                           s_last,
    input  logic [SYS_COLS-1:0]            fifo_full,
    output logic [SYS_COLS-1:0]            wr_en,
    output logic [SYS_COLS*W_BITWIDTH-1:0] din,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int                 c_COL_W    = $clog2(SYS_COLS);
    localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(SYS_COLS - 1);
    localparam logic [ROW_W-1:0]   c_MAX_ROWS = ROW_W'(MAX_ROWS);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_LOAD = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [c_COL_W-1:0]    r_col;
    logic [ROW_W-1:0]      r_row;
    logic [ROW_W-1:0]      r_rows;
    logic                  r_err;
    logic [SYS_COLS-1:0]   r_wr_en;
    logic [W_BITWIDTH-1:0] r_din [SYS_COLS];

    logic [1:0]            w_state_nxt;
    logic [c_COL_W-1:0]    w_col_nxt;
    logic [ROW_W-1:0]      w_row_nxt;
    logic [ROW_W-1:0]      w_rows_nxt;
    logic                  w_err_nxt;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_final;
    logic                  w_start_ok;
    logic [SYS_COLS-1:0]   w_sel;

    // ------------------------------------------------------------------------
    // Handshake and next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // A column's next beat arrives at least SYS_COLS cycles after its
        // previous one, so a registered full flag is always up to date here.
        w_ready    = (r_state == c_S_LOAD) && !fifo_full[r_col];
        w_accept   = s_valid && w_ready;
        w_final    = (r_row == (r_rows - ROW_W'(1))) && (r_col == c_LAST_COL);
        w_start_ok = (tile_rows != '0) && (tile_rows <= c_MAX_ROWS);

        w_sel        = '0;
        w_sel[r_col] = 1'b1;

        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_rows_nxt  = r_rows;
        w_err_nxt   = r_err;

        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    if (w_start_ok) begin
                        w_rows_nxt  = tile_rows;
                        w_col_nxt   = '0;
                        w_row_nxt   = '0;
                        w_err_nxt   = 1'b0;
                        w_state_nxt = c_S_LOAD;
                    end else begin
                        // Illegal tile size: flag it and finish without writing.
                        w_err_nxt   = 1'b1;
                        w_state_nxt = c_S_DONE;
                    end
                end
            end
            c_S_LOAD: begin
                if (w_accept) begin
                    if (w_final) begin
                        w_state_nxt = c_S_DONE;
                        if (!s_last) begin
                            w_err_nxt = 1'b1;
                        end
                    end else if (s_last) begin
                        // Premature end of tile: this beat is still written,
                        // the remaining column entries are abandoned.
                        w_err_nxt   = 1'b1;
                        w_state_nxt = c_S_DONE;
                    end else if (r_col == c_LAST_COL) begin
                        w_col_nxt = '0;
                        w_row_nxt = r_row + ROW_W'(1);
                    end else begin
                        w_col_nxt = r_col + c_COL_W'(1);
                    end
                end
            end
            c_S_DONE: begin
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Counters, error flag and write strobe (one cycle after acceptance)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_rows  <= '0;
            r_err   <= 1'b0;
            r_wr_en <= '0;
        end else begin
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_rows  <= w_rows_nxt;
            r_err   <= w_err_nxt;
            r_wr_en <= w_accept ? w_sel : '0;
        end
    end

    // ------------------------------------------------------------------------
    // Per-column data lanes: only the addressed lane loads, the others hold.
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < SYS_COLS; g++) begin : g_lane
        localparam logic [c_COL_W-1:0] c_LANE = c_COL_W'(g);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_din[g] <= '0;
            end else if (w_accept && (r_col == c_LANE)) begin
                r_din[g] <= s_data;
            end
        end

        assign din[g*W_BITWIDTH +: W_BITWIDTH] = r_din[g];
    end

    assign s_ready = w_ready;
    assign wr_en   = r_wr_en;
    assign busy    = (r_state == c_S_LOAD) || (r_state == c_S_DONE);
    assign done    = (r_state == c_S_DONE);
    assign err     = r_err;

endmodule
`default_nettype wire
